// File: rtl/status_bram_writer.sv
// Free-running producer of the CPU-readable status page: snapshots live status each loop,
// writes it into BRAM port B, then reads and clears the CPU ack word. Option: STATUS_TIMESTAMP_EN.
module status_bram_writer #(
    parameter int                ADDR_W       = 7,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 7'h40,
    parameter int                READ_LATENCY = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              THERMO,
    input  logic              SYNC_SET,
    input  logic [15:0]       STM_IDX,
    input  logic [15:0]       MOD_IDX,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    output logic              BRAM_WE,
    output logic [15:0]       BRAM_DIN,
    input  logic [15:0]       BRAM_DOUT,
    output logic              STATUS_UPDATED
);

    localparam logic [ADDR_W-1:0] A_STATE = BASE_ADDR;
    localparam logic [ADDR_W-1:0] A_STM   = BASE_ADDR + ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_MOD   = BASE_ADDR + ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_CNT   = BASE_ADDR + ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_ACK   = BASE_ADDR + ADDR_W'(4);
`ifdef STATUS_TIMESTAMP_EN
    localparam logic [ADDR_W-1:0] A_TSL   = BASE_ADDR + ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_TSH   = BASE_ADDR + ADDR_W'(6);
`endif
    localparam logic [7:0] WAIT_INIT = (READ_LATENCY > 1) ? 8'(READ_LATENCY - 2) : 8'd0;

    typedef enum logic [3:0] {
        S_SNAP, S_WR0, S_WR1, S_WR2, S_WR3, S_WR5, S_WR6,
        S_REQ, S_WAIT, S_RD_ACK, S_CLR_ACK
    } state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        thermo_sticky;
    logic        sync_sticky;
    logic [15:0] sync_cnt;
    logic [15:0] sh_stm;
    logic [15:0] sh_mod;
    logic [15:0] sh_cnt;
    logic        clr_thermo;
    logic        clr_sync;
    logic        clr_cnt;

    function automatic logic [15:0] count_sync(input logic [15:0] base, input logic pulse);
        if (pulse && (base != 16'hFFFF))
            return base + 16'd1;
        return base;
    endfunction

    always_comb begin
        clr_thermo = 1'b0;
        clr_sync   = 1'b0;
        clr_cnt    = 1'b0;
        if (state == S_RD_ACK) begin
            clr_thermo = BRAM_DOUT[1];
            clr_sync   = BRAM_DOUT[2];
            clr_cnt    = BRAM_DOUT[15];
        end
    end

    // A same-cycle event beats an ack clear; the counter clears first, then counts.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            thermo_sticky <= 1'b0;
            sync_sticky   <= 1'b0;
            sync_cnt      <= 16'h0000;
        end else begin
            thermo_sticky <= (thermo_sticky & ~clr_thermo) | THERMO;
            sync_sticky   <= (sync_sticky & ~clr_sync) | SYNC_SET;
            sync_cnt      <= count_sync(clr_cnt ? 16'h0000 : sync_cnt, SYNC_SET);
        end
    end

`ifdef STATUS_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] sh_ts;

    always_ff @(posedge CLK) begin
        if (!RST_N)
            ts_cnt <= 32'd0;
        else
            ts_cnt <= ts_cnt + 32'd1;
    end
`endif

    // Outputs are registered: each arm sets up what the next state drives onto port B.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state          <= S_SNAP;
            wait_cnt       <= 8'd0;
            BRAM_WE        <= 1'b0;
            BRAM_ADDR      <= A_STATE;
            BRAM_DIN       <= 16'h0000;
            STATUS_UPDATED <= 1'b0;
        end else begin
            BRAM_WE        <= 1'b0;
            STATUS_UPDATED <= 1'b0;
            case (state)
                S_SNAP: begin
                    sh_stm    <= STM_IDX;
                    sh_mod    <= MOD_IDX;
                    sh_cnt    <= sync_cnt;
`ifdef STATUS_TIMESTAMP_EN
                    sh_ts     <= ts_cnt;
`endif
                    BRAM_WE   <= 1'b1;
                    BRAM_ADDR <= A_STATE;
                    BRAM_DIN  <= {13'b0, sync_sticky, thermo_sticky, THERMO};
                    state     <= S_WR0;
                end
                S_WR0: begin
                    BRAM_WE   <= 1'b1;
                    BRAM_ADDR <= A_STM;
                    BRAM_DIN  <= sh_stm;
                    state     <= S_WR1;
                end
                S_WR1: begin
                    BRAM_WE   <= 1'b1;
                    BRAM_ADDR <= A_MOD;
                    BRAM_DIN  <= sh_mod;
                    state     <= S_WR2;
                end
                S_WR2: begin
                    BRAM_WE   <= 1'b1;
                    BRAM_ADDR <= A_CNT;
                    BRAM_DIN  <= sh_cnt;
                    state     <= S_WR3;
                end
`ifdef STATUS_TIMESTAMP_EN
                S_WR3: begin
                    BRAM_WE   <= 1'b1;
                    BRAM_ADDR <= A_TSL;
                    BRAM_DIN  <= sh_ts[15:0];
                    state     <= S_WR5;
                end
                S_WR5: begin
                    BRAM_WE   <= 1'b1;
                    BRAM_ADDR <= A_TSH;
                    BRAM_DIN  <= sh_ts[31:16];
                    state     <= S_WR6;
                end
                S_WR6: begin
                    BRAM_ADDR <= A_ACK;
                    state     <= S_REQ;
                end
`else
                S_WR3: begin
                    BRAM_ADDR <= A_ACK;
                    state     <= S_REQ;
                end
`endif
                S_REQ: begin
                    if (READ_LATENCY > 1) begin
                        wait_cnt <= WAIT_INIT;
                        state    <= S_WAIT;
                    end else begin
                        state    <= S_RD_ACK;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 8'd0)
                        state <= S_RD_ACK;
                    else
                        wait_cnt <= wait_cnt - 8'd1;
                end
                S_RD_ACK: begin
                    if (BRAM_DOUT == 16'h0000) begin
                        STATUS_UPDATED <= 1'b1;
                        BRAM_ADDR      <= A_STATE;
                        state          <= S_SNAP;
                    end else begin
                        BRAM_WE   <= 1'b1;
                        BRAM_DIN  <= 16'h0000;
                        state     <= S_CLR_ACK;
                    end
                end
                S_CLR_ACK: begin
                    STATUS_UPDATED <= 1'b1;
                    BRAM_ADDR      <= A_STATE;
                    state          <= S_SNAP;
                end
                default: state <= S_SNAP;
            endcase
        end
    end

endmodule

// File: tb/tb_status_bram_writer.sv
// Directed bench for status_bram_writer with a 2-cycle-latency BRAM model and a CPU-side ack port.
`timescale 1ns/1ps
module tb_status_bram_writer;

    localparam int         ADDR_W = 7;
    localparam logic [6:0] BASE   = 7'h40;
`ifdef STATUS_TIMESTAMP_EN
    localparam int LOOP_CYC = 10;
    localparam int LOOP_WE  = 6;
`else
    localparam int LOOP_CYC = 8;
    localparam int LOOP_WE  = 4;
`endif

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              THERMO;
    logic              SYNC_SET;
    logic [15:0]       STM_IDX;
    logic [15:0]       MOD_IDX;
    logic [ADDR_W-1:0] BRAM_ADDR;
    logic              BRAM_WE;
    logic [15:0]       BRAM_DIN;
    logic [15:0]       BRAM_DOUT;
    logic              STATUS_UPDATED;

    always #5 CLK = ~CLK;

    status_bram_writer #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .READ_LATENCY(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .THERMO(THERMO), .SYNC_SET(SYNC_SET),
        .STM_IDX(STM_IDX), .MOD_IDX(MOD_IDX), .BRAM_ADDR(BRAM_ADDR), .BRAM_WE(BRAM_WE),
        .BRAM_DIN(BRAM_DIN), .BRAM_DOUT(BRAM_DOUT), .STATUS_UPDATED(STATUS_UPDATED)
    );

    // BRAM model: port B with two-stage read pipeline, plus a CPU write port for the ack word.
    logic [15:0] mem [0:127];
    logic [15:0] rd_p1, rd_p2;
    logic        mem_init;
    logic        cpu_tog, cpu_seen;
    logic [15:0] cpu_data;

    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++)
                mem[i] <= (i == int'(BASE) + 4) ? 16'h0000 : 16'hDEAD;
            cpu_seen <= cpu_tog;
        end else begin
            if (cpu_tog != cpu_seen) begin
                mem[int'(BASE) + 4] <= cpu_data;
                cpu_seen <= cpu_tog;
            end
            if (BRAM_WE)
                mem[BRAM_ADDR] <= BRAM_DIN;
        end
        rd_p1 <= mem[BRAM_ADDR];
        rd_p2 <= rd_p1;
    end
    assign BRAM_DOUT = rd_p2;

    int   n_total = 0;
    int   n_pass  = 0;
    int   loop_cyc;
    int   loop_we;
    logic got_upd;
    int   we_rst;
    logic [31:0] ts_a, ts_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] w(input int k);
        return mem[int'(BASE) + k];
    endfunction

    // Returns at the falling edge of the cycle in which STATUS_UPDATED is high.
    task automatic wait_upd();
        loop_cyc = 0;
        loop_we  = 0;
        got_upd  = 1'b0;
        for (int i = 0; i < 40 && !got_upd; i++) begin
            @(negedge CLK);
            loop_cyc++;
            if (BRAM_WE === 1'b1) loop_we++;
            if (STATUS_UPDATED === 1'b1) got_upd = 1'b1;
        end
        chk("status_updated_seen", 32'(got_upd), 32'd1);
    endtask

    task automatic cpu_ack(input logic [15:0] v);
        cpu_data = v;
        cpu_tog  = ~cpu_tog;
    endtask

    initial begin
        RST_N = 1'b0; THERMO = 1'b0; SYNC_SET = 1'b0;
        STM_IDX = 16'h0000; MOD_IDX = 16'h0000;
        mem_init = 1'b1; cpu_tog = 1'b0; cpu_data = 16'h0000;
        we_rst = 0;

        repeat (4) begin
            @(negedge CLK);
            if (BRAM_WE !== 1'b0) we_rst++;
        end
        chk("we_during_reset", 32'(we_rst), 32'd0);
        chk("reset_addr", 32'(BRAM_ADDR), 32'h40);
        chk("reset_din", 32'(BRAM_DIN), 32'h0);
        chk("reset_updated", 32'(STATUS_UPDATED), 32'h0);
        RST_N = 1'b1; mem_init = 1'b0;

        // Idle loops: everything zero
        wait_upd();
        chk("t1_loop_cycles", 32'(loop_cyc), 32'(LOOP_CYC));
        chk("t1_loop_we", 32'(loop_we), 32'(LOOP_WE));
        chk("t1_word0", 32'(w(0)), 32'h0);
        chk("t1_word1", 32'(w(1)), 32'h0);
        chk("t1_word2", 32'(w(2)), 32'h0);
        chk("t1_word3", 32'(w(3)), 32'h0);
        ts_a = {w(6), w(5)};
        wait_upd();
        chk("t1_loop2_cycles", 32'(loop_cyc), 32'(LOOP_CYC));
        ts_b = {w(6), w(5)};
`ifdef STATUS_TIMESTAMP_EN
        chk("t1_timestamp_delta", ts_b - ts_a, 32'd10);
`endif

        // THERMO pulse outside SNAP, then ack bit1
        @(negedge CLK); THERMO = 1'b1;
        @(negedge CLK); THERMO = 1'b0;
        wait_upd();
        chk("t2_word0_same_loop", 32'(w(0)), 32'h0);
        wait_upd();
        chk("t2_word0_sticky", 32'(w(0)), 32'h0002);
        cpu_ack(16'h0002);
        wait_upd();
        chk("t2_ack_loop_cycles", 32'(loop_cyc), 32'(LOOP_CYC + 1));
        chk("t2_ack_loop_we", 32'(loop_we), 32'(LOOP_WE + 1));
        chk("t2_ack_cleared", 32'(w(4)), 32'h0);
        chk("t2_word0_before_clear", 32'(w(0)), 32'h0002);
        wait_upd();
        chk("t2_word0_after_clear", 32'(w(0)), 32'h0000);
        chk("t2_loop_after_clear", 32'(loop_cyc), 32'(LOOP_CYC));

        // Three SYNC_SET pulses, then ack 8004
        repeat (3) begin
            SYNC_SET = 1'b1; @(negedge CLK);
            SYNC_SET = 1'b0; @(negedge CLK);
        end
        wait_upd();
        wait_upd();
        chk("t3_word3", 32'(w(3)), 32'd3);
        chk("t3_word0", 32'(w(0)), 32'h0004);
        cpu_ack(16'h8004);
        wait_upd();
        wait_upd();
        chk("t3_word3_cleared", 32'(w(3)), 32'd0);
        chk("t3_word0_cleared", 32'(w(0)), 32'h0000);

        // Saturation at 16'hFFFF
        SYNC_SET = 1'b1;
        repeat (65540) @(negedge CLK);
        SYNC_SET = 1'b0;
        @(negedge CLK); SYNC_SET = 1'b1;
        @(negedge CLK); SYNC_SET = 1'b0;
        wait_upd();
        wait_upd();
        chk("t4_word3_saturated", 32'(w(3)), 32'hFFFF);
        chk("t4_word0", 32'(w(0)), 32'h0004);
        cpu_ack(16'h8004);
        wait_upd();
        wait_upd();
        chk("t4_word3_cleared", 32'(w(3)), 32'd0);

        // SYNC_SET coincident with the RD_ACK cycle of an 8004 ack
        cpu_ack(16'h8004);
        repeat (LOOP_CYC - 1) @(negedge CLK);
        SYNC_SET = 1'b1;
        @(negedge CLK);
        SYNC_SET = 1'b0;
        wait_upd();
        wait_upd();
        chk("t5_word0_event_wins", 32'(w(0)), 32'h0004);
        chk("t5_word3_count_after_clear", 32'(w(3)), 32'd1);

        // STM_IDX toggling during the writes
        STM_IDX = 16'h1234; MOD_IDX = 16'hBEEF;
        @(negedge CLK); STM_IDX = 16'hEDCB;
        @(negedge CLK); STM_IDX = 16'h1234;
        @(negedge CLK); STM_IDX = 16'hEDCB;
        @(negedge CLK); STM_IDX = 16'h1234;
        wait_upd();
        chk("t6_word1_snapshot", 32'(w(1)), 32'h1234);
        chk("t6_word2_snapshot", 32'(w(2)), 32'hBEEF);

        // Reset asserted during WR2
        STM_IDX = 16'h7777;
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("t6_midreset_we", 32'(BRAM_WE), 32'h0);
        chk("t6_midreset_addr", 32'(BRAM_ADDR), 32'h40);
        chk("t6_midreset_updated", 32'(STATUS_UPDATED), 32'h0);
        RST_N = 1'b1;
        wait_upd();
        chk("t6_restart_cycles", 32'(loop_cyc), 32'(LOOP_CYC));
        chk("t6_restart_we", 32'(loop_we), 32'(LOOP_WE));
        chk("t6_restart_word0", 32'(w(0)), 32'h0000);
        chk("t6_restart_word1", 32'(w(1)), 32'h7777);
        chk("t6_restart_word3", 32'(w(3)), 32'd0);
`ifdef STATUS_TIMESTAMP_EN
        ts_a = {w(6), w(5)};
        wait_upd();
        ts_b = {w(6), w(5)};
        chk("t6_timestamp_delta", ts_b - ts_a, 32'd10);
`else
        chk("word5_untouched", 32'(w(5)), 32'hDEAD);
        chk("word6_untouched", 32'(w(6)), 32'hDEAD);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
